// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream loader writing a Chip-8 image into program memory.
// Optional readback check enabled by ROM_LOADER_VERIFY_EN.
module rom_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h200,
  parameter int unsigned MAX_LEN   = 4096 - BASE_ADDR
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_en_o,
  output logic        mem_write_o,
  output logic [11:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  checksum_o,
  output logic [11:0] count_o
);

`ifdef ROM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERROR, S_VERIFY
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERROR
  } state_e;
`endif

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_e      state_q;
  logic        in_ready_q;
  logic        mem_en_q;
  logic        mem_write_q;
  logic [11:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  checksum_q;
  logic [11:0] count_q;
  logic [7:0]  len_hi_q;
  logic [11:0] len_q;

`ifdef ROM_LOADER_VERIFY_EN
  logic [11:0] rd_idx_q;
  logic [11:0] ack_idx_q;
  logic [7:0]  vsum_q;
  logic        rd_vld_q;
  logic [7:0]  vsum_d;
`else
  logic        unused_rdata;
  assign unused_rdata = ^mem_rdata_i;
`endif

  logic        xfer;
  logic [15:0] len_d;

  assign xfer  = in_valid_i && in_ready_q;
  assign len_d = {len_hi_q, in_data_i};
`ifdef ROM_LOADER_VERIFY_EN
  assign vsum_d = vsum_q + mem_rdata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      checksum_q  <= '0;
      count_q     <= '0;
      len_hi_q    <= '0;
      len_q       <= '0;
`ifdef ROM_LOADER_VERIFY_EN
      rd_idx_q    <= '0;
      ack_idx_q   <= '0;
      vsum_q      <= '0;
      rd_vld_q    <= 1'b0;
`endif
    end else begin
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
      // Registered memory: read data belongs to the read issued last cycle.
      rd_vld_q    <= mem_en_q && !mem_write_q;
`endif
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state_q    <= S_LEN_HI;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            count_q    <= '0;
            checksum_q <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= in_data_i;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            if (len_d == 16'd0 || len_d > MAX_LEN_W) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              len_q   <= len_d[11:0];
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_en_q    <= 1'b1;
            mem_write_q <= 1'b1;
            mem_addr_q  <= BASE_ADDR + count_q;
            mem_wdata_q <= in_data_i;
            count_q     <= count_q + 12'd1;
            checksum_q  <= checksum_q + in_data_i;
            // Drop ready with the final byte so trailing bytes are refused.
            if (count_q + 12'd1 == len_q) begin
              in_ready_q <= 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
              state_q    <= S_VERIFY;
              rd_idx_q   <= '0;
              ack_idx_q  <= '0;
              vsum_q     <= '0;
`else
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end
          end
        end
`ifdef ROM_LOADER_VERIFY_EN
        S_VERIFY: begin
          if (rd_idx_q != len_q) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= BASE_ADDR + rd_idx_q;
            rd_idx_q   <= rd_idx_q + 12'd1;
          end
          if (rd_vld_q) begin
            vsum_q    <= vsum_d;
            ack_idx_q <= ack_idx_q + 12'd1;
            if (ack_idx_q + 12'd1 == len_q) begin
              busy_q <= 1'b0;
              if (vsum_d == checksum_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end
            end
          end
        end
`endif
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_en_o    = mem_en_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign checksum_o  = checksum_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader.
// Readback scenarios are built when ROM_LOADER_VERIFY_EN is defined.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_en;
  logic        mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  checksum;
  logic [11:0] count;

  rom_loader dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .mem_en_o(mem_en), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .done_o(done), .error_o(error),
    .checksum_o(checksum), .count_o(count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory model: registered read port, optional corruption of 0x201.
  logic [7:0] mem [0:4095];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_en && mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_write)
      mem_rdata <= (corrupt && mem_addr == 12'h201) ? (mem[mem_addr] ^ 8'h5A) : mem[mem_addr];
  end

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t wlog[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  en_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (mem_en && mem_write) wlog.push_back('{mem_addr, mem_wdata, cyc});
    if (done) done_cnt++;
    if (mem_en) en_cnt++;
  end

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
    en_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit to);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    to = (guard >= 20);
    if (!to) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap_max, output bit to);
    bit t;
    to = 1'b0;
    foreach (s[i]) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_byte(s[i], t);
      if (t) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit to);
    int g = 0;
    while (busy === 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    to = (g >= 5000);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [46:0] outs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    outs = {in_ready, mem_en, mem_write, mem_addr, mem_wdata, busy, done, error, checksum, count};
    tests_run++;
    if (outs !== 47'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] payload[$];
    logic [7:0] s[$];
    logic [7:0] ck;
    bit to, to2;
    payload = {8'hA1, 8'hB2, 8'hC3};
    s = {8'h00, 8'h03, payload};
    ck = 8'h00;
    foreach (payload[i]) ck += payload[i];
    clear_log();
    do_start();
    send_stream(s, 0, to);
    wait_idle(to2);
    tests_run++;
    if (to || to2) begin tests_failed++; $display("FAIL basic_timeout: stream %0d idle %0d want 0 0", to, to2); end
    tests_run++;
    if (wlog.size() !== 3) begin
      tests_failed++;
      $display("FAIL basic_wr_count: got %0d want 3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (wlog[i].addr !== 12'h200 + 12'(i) || wlog[i].data !== payload[i]) begin
          tests_failed++;
          $display("FAIL basic_wr%0d: got %h=%h want %h=%h", i, wlog[i].addr, wlog[i].data, 12'h200 + 12'(i), payload[i]);
        end
      end
      tests_run++;
      if (wlog[2].cyc - wlog[0].cyc !== 2) begin
        tests_failed++;
        $display("FAIL basic_consecutive: span %0d want 2", wlog[2].cyc - wlog[0].cyc);
      end
    end
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    tests_run++;
    if (count !== 12'd3) begin tests_failed++; $display("FAIL basic_count: got %0d want 3", count); end
    tests_run++;
    if (checksum !== ck) begin tests_failed++; $display("FAIL basic_checksum: got %h want %h", checksum, ck); end
    tests_run++;
    if ({busy, error, in_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL basic_flags: busy/error/ready got %b want 000", {busy, error, in_ready});
    end
  endtask

  task automatic test_len_errors();
    bit to, to2;
    clear_log();
    do_start();
    send_stream({8'h00, 8'h00}, 0, to);
    wait_idle(to2);
    tests_run++;
    if ({error, busy, in_ready} !== 3'b100 || en_cnt !== 0 || to || to2) begin
      tests_failed++;
      $display("FAIL len_zero: err/busy/ready %b en_cnt %0d want 100 0", {error, busy, in_ready}, en_cnt);
    end
    do_start();
    tests_run++;
    if ({error, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL restart_clears_error: err/busy %b want 01", {error, busy});
    end
    send_stream({8'h0E, 8'h01}, 0, to);
    wait_idle(to2);
    tests_run++;
    if (error !== 1'b1 || wlog.size() !== 0 || en_cnt !== 0 || done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL len_too_big: err %b writes %0d en %0d done %0d want 1 0 0 0", error, wlog.size(), en_cnt, done_cnt);
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] payload[$];
      logic [7:0] s[$];
      logic [7:0] ck;
      int len, bad, nw;
      bit to, to2;
      len = $urandom_range(40, 1);
      payload.delete();
      ck = 8'h00;
      for (int i = 0; i < len; i++) begin
        payload.push_back(8'($urandom));
        ck += payload[i];
      end
      s = {8'(len >> 8), 8'(len), payload};
      clear_log();
      do_start();
      send_stream(s, 3, to);
      wait_idle(to2);
      bad = 0;
      foreach (wlog[i])
        if (i >= len || wlog[i].addr !== 12'(32'h200 + i) || wlog[i].data !== payload[i]) bad++;
      tests_run++;
      if (to || to2 || wlog.size() !== len || bad !== 0) begin
        tests_failed++;
        $display("FAIL gaps_writes[%0d]: writes %0d bad %0d timeout %0d want %0d 0 0", it, wlog.size(), bad, to || to2, len);
      end
      tests_run++;
      if (count !== 12'(len) || checksum !== ck || done_cnt !== 1) begin
        tests_failed++;
        $display("FAIL gaps_result[%0d]: count %0d ck %h done %0d want %0d %h 1", it, count, checksum, done_cnt, len, ck);
      end
      nw = wlog.size();
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) begin
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL trailing_ready[%0d]: got %b want 0", it, in_ready); end
      end
      in_valid = 1'b0;
      tests_run++;
      if (wlog.size() !== nw) begin tests_failed++; $display("FAIL trailing_write[%0d]: got %0d want %0d", it, wlog.size(), nw); end
    end
  endtask

  task automatic test_max_len();
    logic [7:0] payload[$];
    logic [7:0] s[$];
    logic [7:0] ck;
    int bad;
    bit to, to2;
    ck = 8'h00;
    for (int i = 0; i < 3584; i++) begin
      payload.push_back(8'($urandom));
      ck += payload[i];
    end
    s = {8'h0E, 8'h00, payload};
    clear_log();
    do_start();
    send_stream(s, 0, to);
    wait_idle(to2);
    bad = 0;
    foreach (wlog[i])
      if (i >= 3584 || wlog[i].addr !== 12'(32'h200 + i) || wlog[i].data !== payload[i]) bad++;
    tests_run++;
    if (to || to2 || wlog.size() !== 3584 || bad !== 0) begin
      tests_failed++;
      $display("FAIL max_writes: writes %0d bad %0d want 3584 0", wlog.size(), bad);
    end
    tests_run++;
    if (wlog.size() == 0 || wlog[wlog.size() - 1].addr !== 12'hFFF) begin
      tests_failed++;
      $display("FAIL max_last_addr: writes %0d want last addr fff", wlog.size());
    end
    tests_run++;
    if (done_cnt !== 1 || count !== 12'd3584 || checksum !== ck || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_result: done %0d count %0d ck %h err %b want 1 3584 %h 0", done_cnt, count, checksum, error, ck);
    end
  endtask

  task automatic test_reset_mid();
    logic [46:0] outs;
    bit to;
    clear_log();
    do_start();
    send_stream({8'h00, 8'h05, 8'h11, 8'h22}, 0, to);
    reset = 1'b1;
    @(negedge clk);
    outs = {in_ready, mem_en, mem_write, mem_addr, mem_wdata, busy, done, error, checksum, count};
    tests_run++;
    if (to || outs !== 47'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got %h want 0", outs);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (done_cnt !== 0 || error !== 1'b0 || wlog.size() !== 2 || mem[12'h201] !== 8'h22) begin
      tests_failed++;
      $display("FAIL reset_mid_after: done %0d err %b writes %0d want 0 0 2", done_cnt, error, wlog.size());
    end
  endtask

  task automatic test_start_busy();
    bit to, to2;
    clear_log();
    do_start();
    send_stream({8'h00, 8'h04, 8'h01, 8'h02}, 0, to);
    do_start();
    tests_run++;
    if (busy !== 1'b1 || count !== 12'd2) begin
      tests_failed++;
      $display("FAIL start_busy_ignored: busy %b count %0d want 1 2", busy, count);
    end
    send_stream({8'h03, 8'h04}, 2, to2);
    wait_idle(to2);
    tests_run++;
    if (to || to2 || count !== 12'd4 || checksum !== 8'h0A || done_cnt !== 1 || wlog.size() !== 4 || wlog[3].addr !== 12'h203) begin
      tests_failed++;
      $display("FAIL start_busy_result: count %0d ck %h done %0d writes %0d want 4 0a 1 4", count, checksum, done_cnt, wlog.size());
    end
  endtask

`ifdef ROM_LOADER_VERIFY_EN
  task automatic test_verify();
    for (int c = 0; c < 2; c++) begin
      logic [7:0] s[$];
      int len;
      bit to, to2;
      len = $urandom_range(12, 3);
      s = {8'h00, 8'(len)};
      for (int i = 0; i < len; i++) s.push_back(8'($urandom));
      corrupt = (c == 1);
      clear_log();
      do_start();
      send_stream(s, 1, to);
      wait_idle(to2);
      tests_run++;
      if (c == 0 && (to || to2 || done_cnt !== 1 || error !== 1'b0 || en_cnt !== 2 * len)) begin
        tests_failed++;
        $display("FAIL verify_clean: done %0d err %b en %0d want 1 0 %0d", done_cnt, error, en_cnt, 2 * len);
      end
      if (c == 1 && (to || to2 || done_cnt !== 0 || error !== 1'b1)) begin
        tests_failed++;
        $display("FAIL verify_corrupt: done %0d err %b want 0 1", done_cnt, error);
      end
    end
    corrupt = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_errors();
    test_random_gaps();
    test_start_busy();
    test_reset_mid();
    test_max_len();
`ifdef ROM_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
